// File: rtl/sysu_tdm_demux8.sv
// sysu_tdm_demux8: receive end of an 8-channel TDM link fed by an 8-to-1 selector.
// Scans the selector address A through slots 0..7, samples D once per slot and
// publishes the rebuilt word on Y with a one-cycle VALID pulse per frame.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | not scanning, S_n=1, A=0; waits for EN_n=0
// SCAN  | S_n=0, one slot sampled per edge, frame completes at A=7
// GAP   | S_n=1, A=0, idles GAP_CYCLES edges between frames
module sysu_tdm_demux8 #(
  parameter int GAP_CYCLES = 2,
  parameter bit INVERT     = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN_n,
  input  logic       D,
  output logic [2:0] A,
  output logic       S_n,
  output logic [7:0] Y,
  output logic       VALID,
  output logic [7:0] FRAMES
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam bit         HAS_GAP  = (GAP_CYCLES > 0);
  // Down-counter load: the GAP state is left on the edge where the count is zero.
  localparam logic [3:0] GAP_LOAD = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

  logic [1:0] state;
  logic [3:0] gap_cnt;
  logic [6:0] shadow;
  logic       bit_in;
  logic       scan_abort;
  logic       frame_done;

  assign bit_in = D ^ INVERT;

  // An EN_n=1 edge in SCAN aborts the frame even on slot 7, so a frame only
  // completes when enable was held through all eight samples.
  assign scan_abort = (state == ST_SCAN) && EN_n;
  assign frame_done = (state == ST_SCAN) && !EN_n && (A == 3'd7);

  assign S_n = (state != ST_SCAN);

  // Sequencer: state, slot address and inter-frame gap timer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      A       <= 3'd0;
      gap_cnt <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          A <= 3'd0;
          if (!EN_n) state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (scan_abort) begin
            state <= ST_IDLE;
            A     <= 3'd0;
          end else if (frame_done) begin
            A <= 3'd0;
            if (HAS_GAP) begin
              state   <= ST_GAP;
              gap_cnt <= GAP_LOAD;
            end
          end else begin
            A <= A + 3'd1;
          end
        end
        ST_GAP: begin
          A <= 3'd0;
          if (gap_cnt == 4'd0) begin
            state <= EN_n ? ST_IDLE : ST_SCAN;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          A     <= 3'd0;
        end
      endcase
    end
  end

  // Data path: slot capture into the shadow word, frame publish, frame counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow <= 7'd0;
      Y      <= 8'd0;
      VALID  <= 1'b0;
      FRAMES <= 8'd0;
    end else begin
      VALID <= 1'b0;
      if ((state == ST_SCAN) && (A != 3'd7)) begin
        shadow[A] <= bit_in;
      end
      // Slot 7 goes straight into Y, so the shadow only holds slots 0..6.
      if (frame_done) begin
        Y      <= {bit_in, shadow};
        VALID  <= 1'b1;
        FRAMES <= FRAMES + 8'd1;
      end
    end
  end

endmodule
